apb_arbiter: RTL and testbench
==============================

APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of upstream requesters (2..8).
REQ-002 SHALL have parameter AW, default 8, address width.
REQ-003 SHALL have parameter DW, default 8, data width.
REQ-004 SHALL have parameter TMO, default 16, max XFER cycles before abort (2..255).
REQ-005 SHALL have one clock and a synchronous, active-high reset: port pclk, input, 1, rising-edge clock for all state.
REQ-006 SHALL have port preset, input, 1, synchronous active-high reset sampled on pclk.
REQ-007 SHALL have port up_wr_req, input, NREQ, per-requester write request, level, held until own ack.
REQ-008 SHALL have port up_wr_addr, input, NREQ*AW, requester i in slice [i*AW +: AW].
REQ-009 SHALL have port up_wr_data, input, NREQ*DW, requester i in slice [i*DW +: DW].
REQ-010 SHALL have port up_rd_req, input, NREQ, per-requester read request, level, held until own ack.
REQ-011 SHALL have port up_rd_addr, input, NREQ*AW, requester i in slice [i*AW +: AW].
REQ-012 SHALL have port up_wr_ack, output, NREQ, one-cycle write-done pulse to granted requester.
REQ-013 SHALL have port up_rd_ack, output, NREQ, one-cycle read-done pulse to granted requester.
REQ-014 SHALL have port up_rd_data, output, DW, shared read data, valid only while any up_rd_ack bit is high.
REQ-015 SHALL have port up_err, output, 1, high with the ack pulse when the transfer timed out.
REQ-016 SHALL have port grant, output, NREQ, one-hot owner of the converter, zero when idle.
REQ-017 SHALL have ports write_req (1), write_addr (AW), write_data (DW), all outputs, to the apb_converter write master port.
REQ-018 SHALL have port write_ack, input, 1, converter write completion.
REQ-019 SHALL have ports read_req (1) and read_addr (AW), both outputs, to the converter read master port.
REQ-020 SHALL have ports read_data (DW) and read_ack (1), both inputs, from the converter read master port.

Function
REQ-021 SHALL implement FSM states IDLE, XFER, ACK, HOLD.
REQ-022 In IDLE with any up_wr_req|up_rd_req bit set: pick winner, latch its op, addr and data, set grant, go to XFER.
REQ-023 Winner: round-robin; search starts at ptr, ascending index, wrapping at NREQ-1 -> 0.
REQ-024 After each grant, ptr SHALL become (winner+1) mod NREQ.
REQ-025 If a requester asserts both requests, write SHALL win; its read is served on a later grant.
REQ-026 In XFER: exactly one of write_req/read_req SHALL be high, with latched addr/data held stable (registered, asserted first cycle of XFER).
REQ-027 Upstream addr/data changes during XFER SHALL NOT affect downstream outputs.
REQ-028 XFER -> ACK when the matching ack (write_ack for write, read_ack for read) is sampled high.
REQ-029 Ack of the non-issued type in XFER SHALL be ignored.
REQ-030 XFER timer counts cycles in XFER; if the count reaches TMO without ack -> ACK with up_err=1.
REQ-031 In ACK: write_req/read_req low; exactly one up_*_ack bit of the winner high for one cycle.
REQ-032 In ACK for a read: up_rd_data = read_data captured on the ack edge, or 0 on timeout.
REQ-033 In HOLD: no request accepted, grant=0; requester SHALL drop its request by end of HOLD. HOLD -> IDLE.
REQ-034 Min back-to-back spacing: 1 IDLE + XFER + ACK + HOLD; a downstream ack in the first XFER cycle gives 4 cycles per transfer.
REQ-035 A new request arriving while not IDLE SHALL wait; requests SHALL never be dropped.

Reset
REQ-036 preset high at a pclk edge SHALL force IDLE, ptr=0, timer=0.
REQ-037 During reset, all outputs SHALL be 0 (write_req, read_req, addresses, data, acks, up_err, grant, up_rd_data).
REQ-038 Reset mid-XFER SHALL drop the downstream request next edge with no upstream ack; the transfer is abandoned.

Verification
REQ-039 Single write: req1 wr addr 0xCC data 0xAC -> write_addr=0xCC, write_data=0xAC, grant=4'b0010; one up_wr_ack[1] pulse, up_err=0.
REQ-040 Single read: req2 rd addr 0x55, converter returns 0xFF -> read_addr=0x55; up_rd_ack[2] pulse with up_rd_data=0xFF.
REQ-041 All 4 write requests simultaneous from reset -> grants in order 0,1,2,3, each acked once; then ptr=0.
REQ-042 Requester 3 asserts write 0x50@0xF5 and read @0x10 together -> write issued first, read on the next grant of 3.
REQ-043 Converter never acks, TMO=16 -> read_req high exactly 16 cycles, then ack pulse with up_err=1 and up_rd_data=0.
REQ-044 preset asserted in the 2nd XFER cycle -> write_req=0 next cycle, no ack, grant=0; a fresh request is then served normally.

Source files
------------

// File: rtl/apb_arbiter.sv
// apb_arbiter
//   Round-robin arbiter that multiplexes NREQ upstream requesters onto the
//   single write/read master ports of an apb_converter. One transfer is in
//   flight at a time. A transfer goes IDLE -> XFER -> ACK -> HOLD -> IDLE, so
//   back-to-back transfers are at least four cycles apart. A transfer that
//   gets no downstream ack within TMO cycles is completed with up_err set.
//
// Ports
//   pclk, preset          : clock and synchronous active-high reset
//   up_wr_req/addr/data   : per-requester write request (level, held to ack)
//   up_rd_req/addr        : per-requester read request (level, held to ack)
//   up_wr_ack, up_rd_ack  : one-cycle completion pulse to the granted requester
//   up_rd_data            : shared read data, valid with an up_rd_ack bit
//   up_err                : timeout flag, valid with the ack pulse
//   grant                 : one-hot current owner, zero when not transferring
//   write_req/addr/data   : converter write master request
//   write_ack             : converter write completion
//   read_req/addr         : converter read master request
//   read_data, read_ack   : converter read completion and data
module apb_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 8,
  parameter int TMO  = 16
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic [NREQ-1:0]    up_wr_req,
  input  logic [NREQ*AW-1:0] up_wr_addr,
  input  logic [NREQ*DW-1:0] up_wr_data,
  input  logic [NREQ-1:0]    up_rd_req,
  input  logic [NREQ*AW-1:0] up_rd_addr,
  output logic [NREQ-1:0]    up_wr_ack,
  output logic [NREQ-1:0]    up_rd_ack,
  output logic [DW-1:0]      up_rd_data,
  output logic               up_err,
  output logic [NREQ-1:0]    grant,
  output logic               write_req,
  output logic [AW-1:0]      write_addr,
  output logic [DW-1:0]      write_data,
  input  logic               write_ack,
  output logic               read_req,
  output logic [AW-1:0]      read_addr,
  input  logic [DW-1:0]      read_data,
  input  logic               read_ack
);

  localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  typedef enum logic [1:0] {IDLE, XFER, ACK, HOLD} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [7:0]      timer_q, timer_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            op_wr_q, op_wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] any_req;
  logic            hi_found, lo_found;
  logic [PW-1:0]   hi_idx, lo_idx;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;
  logic            win_wr;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  assign any_req = up_wr_req | up_rd_req;

  // Round-robin pick: the lowest requesting index at or above ptr wins; if
  // there is none, the search wraps and the lowest requesting index wins.
  // Scanning downward lets the last hit in each pass be the lowest index.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (any_req[i]) begin
        lo_found = 1'b1;
        lo_idx   = PW'(i);
        if (PW'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = PW'(i);
        end
      end
    end
    win_found = lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Winner's operation and operands; a pending write beats a pending read
  // from the same requester, the read stays pending for a later grant.
  always_comb begin
    win_onehot = '0;
    win_wr     = 1'b0;
    win_addr   = '0;
    win_data   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_onehot[i] = 1'b1;
        win_wr        = up_wr_req[i];
        win_addr      = up_wr_req[i] ? up_wr_addr[i*AW +: AW] : up_rd_addr[i*AW +: AW];
        win_data      = up_wr_req[i] ? up_wr_data[i*DW +: DW] : '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    timer_d   = timer_q;
    grant_d   = grant_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d   = XFER;
          grant_d   = win_onehot;
          op_wr_d   = win_wr;
          addr_d    = win_addr;
          data_d    = win_data;
          ptr_d     = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          timer_d   = '0;
          err_d     = 1'b0;
          rd_data_d = '0;
        end
      end
      XFER: begin
        // Only the ack matching the issued operation ends the transfer;
        // a real ack on the last allowed cycle still beats the timeout.
        if (op_wr_q ? write_ack : read_ack) begin
          state_d   = ACK;
          rd_data_d = op_wr_q ? '0 : read_data;
          err_d     = 1'b0;
          timer_d   = '0;
        end else if (timer_q == TMO_LAST) begin
          state_d   = ACK;
          rd_data_d = '0;
          err_d     = 1'b1;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ACK: begin
        state_d = HOLD;
        grant_d = '0;
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset clears the latched operands too, so every output reads zero after
  // a reset edge and an in-flight transfer is simply abandoned.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      timer_q   <= '0;
      grant_q   <= '0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      timer_q   <= timer_d;
      grant_q   <= grant_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  // All outputs are decoded from registered state only, so upstream
  // changes during a transfer never reach the converter ports.
  assign write_req  = (state_q == XFER) && op_wr_q;
  assign read_req   = (state_q == XFER) && !op_wr_q;
  assign write_addr = op_wr_q ? addr_q : '0;
  assign write_data = op_wr_q ? data_q : '0;
  assign read_addr  = op_wr_q ? '0 : addr_q;
  assign grant      = grant_q;
  assign up_wr_ack  = ((state_q == ACK) && op_wr_q) ? grant_q : '0;
  assign up_rd_ack  = ((state_q == ACK) && !op_wr_q) ? grant_q : '0;
  assign up_err     = (state_q == ACK) && err_q;
  assign up_rd_data = ((state_q == ACK) && !op_wr_q) ? rd_data_q : '0;

endmodule

// File: tb/tb_apb_arbiter.sv
module tb_apb_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int TMO  = 16;

  logic               pclk;
  logic               preset;
  logic [NREQ-1:0]    up_wr_req;
  logic [NREQ*AW-1:0] up_wr_addr;
  logic [NREQ*DW-1:0] up_wr_data;
  logic [NREQ-1:0]    up_rd_req;
  logic [NREQ*AW-1:0] up_rd_addr;
  logic [NREQ-1:0]    up_wr_ack;
  logic [NREQ-1:0]    up_rd_ack;
  logic [DW-1:0]      up_rd_data;
  logic               up_err;
  logic [NREQ-1:0]    grant;
  logic               write_req;
  logic [AW-1:0]      write_addr;
  logic [DW-1:0]      write_data;
  logic               write_ack;
  logic               read_req;
  logic [AW-1:0]      read_addr;
  logic [DW-1:0]      read_data;
  logic               read_ack;

  apb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .pclk(pclk), .preset(preset),
    .up_wr_req(up_wr_req), .up_wr_addr(up_wr_addr), .up_wr_data(up_wr_data),
    .up_rd_req(up_rd_req), .up_rd_addr(up_rd_addr),
    .up_wr_ack(up_wr_ack), .up_rd_ack(up_rd_ack), .up_rd_data(up_rd_data),
    .up_err(up_err), .grant(grant),
    .write_req(write_req), .write_addr(write_addr), .write_data(write_data),
    .write_ack(write_ack),
    .read_req(read_req), .read_addr(read_addr),
    .read_data(read_data), .read_ack(read_ack)
  );

  typedef struct packed {
    logic [1:0] idx;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   ack_cyc[$];
  int   n_assert;
  int   n_fail;
  int   cyc;
  logic busy_prev;
  int   rd_run;
  int   last_rd_run;

  // converter model controls
  int         cv_delay;
  logic       cv_mute;
  logic       cv_bogus;
  logic [7:0] cv_rdata;
  int         cv_wait;

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Converter model: acks after cv_delay wait cycles, never when muted;
  // with cv_bogus it drives the wrong-type ack while waiting.
  initial begin
    write_ack = 1'b0;
    read_ack  = 1'b0;
    read_data = '0;
    cv_wait   = 0;
    forever begin
      @(negedge pclk);
      write_ack = 1'b0;
      read_ack  = 1'b0;
      read_data = cv_rdata;
      if (!cv_mute && (write_req || read_req)) begin
        if (cv_wait >= cv_delay) begin
          write_ack = write_req;
          read_ack  = read_req;
          cv_wait   = 0;
        end else begin
          cv_wait++;
          if (cv_bogus) begin
            write_ack = read_req;
            read_ack  = write_req;
          end
        end
      end else begin
        cv_wait = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input logic wr, input logic [7:0] addr,
                      input logic [7:0] data, input logic err, input logic [7:0] rdata);
    exp_t e;
    e.idx   = 2'(idx);
    e.wr    = wr;
    e.addr  = addr;
    e.data  = data;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t            e;
    logic [NREQ-1:0] oh;
    if ((write_req || read_req) && !busy_prev) begin
      chk("xfer_expected", 32'(sb.size() != 0), 32'h1);
      if (sb.size() != 0) begin
        e  = sb[0];
        oh = 4'b0001 << e.idx;
        chk("xfer_grant", 32'(grant), 32'(oh));
        chk("xfer_write_req", 32'(write_req), 32'(e.wr));
        chk("xfer_read_req", 32'(read_req), 32'(!e.wr));
        if (e.wr) begin
          chk("write_addr", 32'(write_addr), 32'(e.addr));
          chk("write_data", 32'(write_data), 32'(e.data));
        end else begin
          chk("read_addr", 32'(read_addr), 32'(e.addr));
        end
      end
    end
    busy_prev = write_req || read_req;
    if (read_req) begin
      rd_run++;
    end else begin
      if (rd_run != 0) last_rd_run = rd_run;
      rd_run = 0;
    end
    if (up_wr_ack != '0 || up_rd_ack != '0) begin
      ack_cyc.push_back(cyc);
      chk("ack_expected", 32'(sb.size() != 0), 32'h1);
      if (sb.size() != 0) begin
        e  = sb.pop_front();
        oh = 4'b0001 << e.idx;
        chk("up_wr_ack", 32'(up_wr_ack), e.wr ? 32'(oh) : 32'h0);
        chk("up_rd_ack", 32'(up_rd_ack), e.wr ? 32'h0 : 32'(oh));
        chk("up_err", 32'(up_err), 32'(e.err));
        chk("ack_grant", 32'(grant), 32'(oh));
        if (!e.wr) chk("up_rd_data", 32'(up_rd_data), 32'(e.rdata));
      end
    end else begin
      chk("err_without_ack", 32'(up_err), 32'h0);
    end
    // requesters release their request once acked
    up_wr_req = up_wr_req & ~up_wr_ack;
    up_rd_req = up_rd_req & ~up_rd_ack;
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || up_wr_req != '0 || up_rd_req != '0) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 32'(sb.size()), 32'h0);
    repeat (2) step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_write_req"}, 32'(write_req), 32'h0);
    chk({tag, "_read_req"}, 32'(read_req), 32'h0);
    chk({tag, "_write_addr"}, 32'(write_addr), 32'h0);
    chk({tag, "_write_data"}, 32'(write_data), 32'h0);
    chk({tag, "_read_addr"}, 32'(read_addr), 32'h0);
    chk({tag, "_up_wr_ack"}, 32'(up_wr_ack), 32'h0);
    chk({tag, "_up_rd_ack"}, 32'(up_rd_ack), 32'h0);
    chk({tag, "_up_rd_data"}, 32'(up_rd_data), 32'h0);
    chk({tag, "_up_err"}, 32'(up_err), 32'h0);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
  endtask

  initial begin
    int n;
    n_assert    = 0;
    n_fail      = 0;
    cyc         = 0;
    busy_prev   = 1'b0;
    rd_run      = 0;
    last_rd_run = 0;
    cv_delay    = 0;
    cv_mute     = 1'b0;
    cv_bogus    = 1'b0;
    cv_rdata    = '0;
    preset      = 1'b1;
    up_wr_req   = '0;
    up_rd_req   = '0;
    up_wr_addr  = '0;
    up_wr_data  = '0;
    up_rd_addr  = '0;

    // reset state
    repeat (3) step();
    check_all_zero("reset");
    preset = 1'b0;
    step();

    // single write from requester 1
    up_wr_addr[1*AW +: AW] = 8'hCC;
    up_wr_data[1*DW +: DW] = 8'hAC;
    push(1, 1'b1, 8'hCC, 8'hAC, 1'b0, 8'h00);
    up_wr_req[1] = 1'b1;
    drain(30, "single_wr");
    chk("idle_grant", 32'(grant), 32'h0);

    // single read from requester 2, wrong-type ack driven while waiting
    cv_delay = 2;
    cv_bogus = 1'b1;
    cv_rdata = 8'hFF;
    up_rd_addr[2*AW +: AW] = 8'h55;
    push(2, 1'b0, 8'h55, 8'h00, 1'b0, 8'hFF);
    up_rd_req[2] = 1'b1;
    drain(30, "single_rd");
    chk("rd_len", 32'(last_rd_run), 32'd3);
    cv_delay = 0;
    cv_bogus = 1'b0;

    // all four writes together from reset: order 0,1,2,3, four cycles apart
    preset = 1'b1;
    repeat (2) step();
    preset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      up_wr_addr[i*AW +: AW] = 8'(8'h10 + i);
      up_wr_data[i*DW +: DW] = 8'(8'hA0 + i);
      push(i, 1'b1, 8'(8'h10 + i), 8'(8'hA0 + i), 1'b0, 8'h00);
    end
    ack_cyc.delete();
    up_wr_req = 4'b1111;
    drain(60, "rr_all");
    chk("rr_ack_count", 32'(ack_cyc.size()), 32'd4);
    for (int k = 1; k < 4; k++) begin
      if (k < ack_cyc.size()) chk("rr_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd4);
    end

    // pointer wrapped back to 0: requester 0 beats requester 1
    up_wr_addr[0*AW +: AW] = 8'h20;
    up_wr_data[0*DW +: DW] = 8'hB0;
    up_wr_addr[1*AW +: AW] = 8'h21;
    up_wr_data[1*DW +: DW] = 8'hB1;
    push(0, 1'b1, 8'h20, 8'hB0, 1'b0, 8'h00);
    push(1, 1'b1, 8'h21, 8'hB1, 1'b0, 8'h00);
    up_wr_req = 4'b0011;
    drain(40, "ptr_wrap");

    // requester 3 write+read together, requester 0 write; ptr is 2
    cv_rdata = 8'h3C;
    up_wr_addr[3*AW +: AW] = 8'hF5;
    up_wr_data[3*DW +: DW] = 8'h50;
    up_rd_addr[3*AW +: AW] = 8'h10;
    up_wr_addr[0*AW +: AW] = 8'h01;
    up_wr_data[0*DW +: DW] = 8'h02;
    push(3, 1'b1, 8'hF5, 8'h50, 1'b0, 8'h00);
    push(0, 1'b1, 8'h01, 8'h02, 1'b0, 8'h00);
    push(3, 1'b0, 8'h10, 8'h00, 1'b0, 8'h3C);
    up_wr_req = 4'b1001;
    up_rd_req = 4'b1000;
    drain(50, "wr_before_rd");

    // converter never acks: read times out after TMO cycles
    cv_mute  = 1'b1;
    cv_rdata = 8'hEE;
    up_rd_addr[1*AW +: AW] = 8'h77;
    push(1, 1'b0, 8'h77, 8'h00, 1'b1, 8'h00);
    up_rd_req[1] = 1'b1;
    drain(40, "timeout");
    chk("tmo_len", 32'(last_rd_run), 32'(TMO));

    // reset in the second XFER cycle abandons the write
    up_wr_addr[2*AW +: AW] = 8'h33;
    up_wr_data[2*DW +: DW] = 8'h44;
    push(2, 1'b1, 8'h33, 8'h44, 1'b0, 8'h00);
    up_wr_req[2] = 1'b1;
    n = 0;
    while (!write_req && n < 10) begin
      step();
      n++;
    end
    chk("mid_xfer_start", 32'(write_req), 32'h1);
    step();
    chk("mid_xfer_second", 32'(write_req), 32'h1);
    preset       = 1'b1;
    up_wr_req[2] = 1'b0;
    step();
    check_all_zero("mid_reset");
    sb.delete();
    preset  = 1'b0;
    cv_mute = 1'b0;
    repeat (4) step();
    chk("abandoned_idle_grant", 32'(grant), 32'h0);

    // fresh request after the abandoned one
    up_wr_addr[0*AW +: AW] = 8'h88;
    up_wr_data[0*DW +: DW] = 8'h99;
    push(0, 1'b1, 8'h88, 8'h99, 1'b0, 8'h00);
    up_wr_req[0] = 1'b1;
    drain(30, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
